// File: rtl/nios_ii_system_pio_pkg.sv
// Shared register map for the Nios II PIO slave family.
// Also used by the firmware header generator.
package nios_ii_system_pio_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SET       = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CLEAR     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PULSE     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd6;

  localparam int unsigned STATUS_ACTIVE_BIT = 0;

endpackage

// File: rtl/nios_ii_system_pio_pulse_timer.sv
// Shared pulse down-counter: load restarts it at max(len,1).
// expire is high during the last cycle of the pulse; cancel stops it silently.
module nios_ii_system_pio_pulse_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             cancel,
  output logic             expire,
  output logic             active
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  assign expire = active_q && (cnt_q == CNT_W'(1));
  assign active = active_q;

  // A load wins over both cancel and expiry on the same edge.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = (len == '0) ? CNT_W'(1) : len;
      active_d = 1'b1;
    end else if (cancel || expire) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/nios_ii_system_pio_out_ex.sv
// Avalon-MM output PIO with atomic set/clear/toggle and hardware-timed pulses.
// Zero-wait-state writes, combinational read mux.
module nios_ii_system_pio_out_ex
  import nios_ii_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 12,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
  parameter int unsigned      CNT_W           = 16,
  parameter int unsigned      PULSE_LEN_RESET = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [CNT_W-1:0] LEN_RESET = CNT_W'(PULSE_LEN_RESET);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic             tmr_load;
  logic             tmr_cancel;
  logic             tmr_expire;
  logic             tmr_active;
  logic             writedata_unused;

  assign wr_en            = chipselect && !write_n;
  assign wr_bits          = writedata[WIDTH-1:0];
  assign writedata_unused = &{1'b0, writedata};

  // Apply the bus write first, then let expiry clear whatever is still pulsed.
  always_comb begin
    data_d     = data_q;
    mask_d     = mask_q;
    len_d      = len_q;
    tmr_load   = 1'b0;
    tmr_cancel = 1'b0;
    if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          data_d     = wr_bits;
          mask_d     = '0;
          tmr_cancel = 1'b1;
        end
        ADDR_SET: begin
          data_d     = data_q | wr_bits;
          mask_d     = mask_q & ~wr_bits;
          tmr_cancel = (mask_d == '0);
        end
        ADDR_CLEAR: begin
          data_d     = data_q & ~wr_bits;
          mask_d     = mask_q & ~wr_bits;
          tmr_cancel = (mask_d == '0);
        end
        ADDR_TOGGLE: begin
          data_d     = data_q ^ wr_bits;
          mask_d     = mask_q & ~wr_bits;
          tmr_cancel = (mask_d == '0);
        end
        ADDR_PULSE: begin
          if (wr_bits != '0) begin
            data_d   = data_q | wr_bits;
            mask_d   = mask_q | wr_bits;
            tmr_load = 1'b1;
          end
        end
        ADDR_PULSE_LEN: begin
          len_d = writedata[CNT_W-1:0];
        end
        default: begin
        end
      endcase
    end
    if (tmr_expire && !tmr_load) begin
      data_d = data_d & ~mask_d;
      mask_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
      len_q  <= LEN_RESET;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      len_q  <= len_d;
    end
  end

  nios_ii_system_pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_pulse_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .len     (len_q),
    .cancel  (tmr_cancel),
    .expire  (tmr_expire),
    .active  (tmr_active)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_q);
      ADDR_PULSE:     readdata = 32'(mask_q);
      ADDR_PULSE_LEN: readdata = 32'(len_q);
      ADDR_STATUS:    readdata[STATUS_ACTIVE_BIT] = tmr_active;
      default:        readdata = '0;
    endcase
  end

  assign out_port = data_q;

endmodule

// File: tb/tb_nios_ii_system_pio_out_ex.sv
// Self-checking bench for nios_ii_system_pio_out_ex: vector table, pulse corner sequences,
// and randomized traffic against a deadline-based reference model.
module tb_nios_ii_system_pio_out_ex;

  localparam logic [11:0] RST_VAL = 12'hA5A;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [11:0] out_port;

  int errors = 0;
  int checks = 0;

  // Reference model: pulsed bits expire at an absolute edge number.
  logic [11:0] m_data;
  logic [11:0] m_mask;
  logic [15:0] m_len;
  bit          m_active;
  int          m_deadline;
  int          edge_no = 0;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [11:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  nios_ii_system_pio_out_ex #(
    .WIDTH           (12),
    .RESET_VALUE     (RST_VAL),
    .CNT_W           (16),
    .PULSE_LEN_RESET (50000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0:    return {20'b0, m_data};
      3'd4:    return {20'b0, m_mask};
      3'd5:    return {16'b0, m_len};
      3'd6:    return {31'b0, m_active};
      default: return 32'b0;
    endcase
  endfunction

  task automatic modelReset();
    m_data     = RST_VAL;
    m_mask     = '0;
    m_len      = 16'd50000;
    m_active   = 1'b0;
    m_deadline = 0;
  endtask

  task automatic modelEdge();
    logic [11:0] w;
    bit          loaded;
    int          len_eff;
    w      = writedata[11:0];
    loaded = 1'b0;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: begin m_data = w; m_mask = '0; m_active = 1'b0; end
        3'd1: begin m_data = m_data | w;  m_mask = m_mask & ~w; end
        3'd2: begin m_data = m_data & ~w; m_mask = m_mask & ~w; end
        3'd3: begin m_data = m_data ^ w;  m_mask = m_mask & ~w; end
        3'd4: begin
          if (w != 0) begin
            m_data     = m_data | w;
            m_mask     = m_mask | w;
            m_active   = 1'b1;
            len_eff    = (m_len == 0) ? 1 : int'(m_len);
            m_deadline = edge_no + len_eff;
            loaded     = 1'b1;
          end
        end
        3'd5: m_len = writedata[15:0];
        default: ;
      endcase
    end
    if (m_mask == 0) m_active = 1'b0;
    if (m_active && !loaded && edge_no == m_deadline) begin
      m_data   = m_data & ~m_mask;
      m_mask   = '0;
      m_active = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, edge_no, act, exp);
    end
  endtask

  task automatic driveIn(input logic cs, input logic wn, input logic [2:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = addr;
    writedata  = wdata;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    edge_no++;
    if (reset_n) modelEdge();
    else modelReset();
    #1;
  endtask

  task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] addr, input logic [31:0] wdata);
    driveIn(cs, wn, addr, wdata);
    #1;
    checkOutput("readdata", readdata, modelRead(addr));
    stepEdge();
    checkOutput("out_port", {20'b0, out_port}, {20'b0, m_data});
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wdata);
    applyStimulus(1'b1, 1'b0, addr, wdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 3'd6, 32'h0);
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("reset_out", {20'b0, out_port}, 32'h0000_0A5A);
    address = 3'd5;
    #1;
    checkOutput("reset_len", readdata, 32'd50000);
    address = 3'd6;
    #1;
    checkOutput("reset_status", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0000_00F0, 32'h0000_0A5A, 12'h0F0});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0000_000F, 32'h0000_0000, 12'h0FF});
    vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h0000_0030, 32'h0000_0000, 12'h0CF});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0000_0801, 32'h0000_0000, 12'h8CE});
    vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0000_0000, 32'h0000_08CE, 12'h8CE});
    vecs.push_back('{1'b1, 1'b1, 3'd5, 32'h0000_0000, 32'd50000,     12'h8CE});
    vecs.push_back('{1'b1, 1'b1, 3'd7, 32'h0000_0000, 32'h0000_0000, 12'h8CE});
    vecs.push_back('{1'b1, 1'b0, 3'd7, 32'h0000_0FFF, 32'h0000_0000, 12'h8CE});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 32'hFFFF_F123, 32'h0000_08CE, 12'h123});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0000_0FFF, 32'h0000_0123, 12'h123});
    vecs.push_back('{1'b1, 1'b1, 3'd4, 32'h0000_0FFF, 32'h0000_0000, 12'h123});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0000_0000, 32'h0000_0000, 12'h123});
    vecs.push_back('{1'b1, 1'b1, 3'd6, 32'h0000_0000, 32'h0000_0000, 12'h123});

    foreach (vecs[i]) begin
      driveIn(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata);
      #1;
      checkOutput($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      stepEdge();
      checkOutput($sformatf("vec%0d_out", i), {20'b0, out_port}, {20'b0, vecs[i].exp_out});
    end

    // Five-cycle pulse on bits 1:0.
    wr(3'd0, 32'h0);
    wr(3'd5, 32'd5);
    wr(3'd4, 32'h003);
    checkOutput("p5_start", {20'b0, out_port}, 32'h003);
    for (int i = 1; i < 5; i++) begin
      idle(1);
      checkOutput("p5_hold", {20'b0, out_port}, 32'h003);
    end
    driveIn(1'b0, 1'b1, 3'd6, 32'h0);
    #1;
    checkOutput("p5_status_busy", readdata, 32'd1);
    stepEdge();
    checkOutput("p5_end", {20'b0, out_port}, 32'h000);
    driveIn(1'b0, 1'b1, 3'd6, 32'h0);
    #1;
    checkOutput("p5_status_idle", readdata, 32'd0);

    // Zero length behaves as a single cycle.
    wr(3'd5, 32'd0);
    wr(3'd4, 32'h100);
    checkOutput("p0_start", {20'b0, out_port}, 32'h100);
    idle(1);
    checkOutput("p0_end", {20'b0, out_port}, 32'h000);

    // Retrigger at T+4 restarts the shared count for both bits.
    wr(3'd0, 32'h0);
    wr(3'd5, 32'd10);
    wr(3'd4, 32'h001);
    idle(3);
    wr(3'd4, 32'h002);
    idle(9);
    checkOutput("retrig_hold", {20'b0, out_port}, 32'h003);
    idle(1);
    checkOutput("retrig_end", {20'b0, out_port}, 32'h000);

    // CLEAR removes one bit from the running pulse; the other keeps its deadline.
    wr(3'd4, 32'h003);
    idle(2);
    wr(3'd2, 32'h001);
    checkOutput("clr_bit0", {20'b0, out_port}, 32'h002);
    idle(6);
    checkOutput("clr_bit1_hold", {20'b0, out_port}, 32'h002);
    idle(1);
    checkOutput("clr_bit1_end", {20'b0, out_port}, 32'h000);

    // Asynchronous reset in the middle of a pulse.
    wr(3'd5, 32'd8);
    wr(3'd4, 32'h0FF);
    idle(3);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("areset_out", {20'b0, out_port}, 32'h0000_0A5A);
    chipselect = 1'b0;
    address    = 3'd6;
    #1;
    checkOutput("areset_status", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    checkOutput("areset_no_expiry", {20'b0, out_port}, 32'h0000_0A5A);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd5) d = 32'($urandom_range(0, 12));
      else if ($urandom_range(0, 1) == 1) d = d & $urandom;
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
